// File: rtl/uart_rx_if.sv
// uart_rx_if -- consumer-side bundle of the UART receiver.
//   rx_data    : received data word (DATA_BITS wide)
//   rx_valid   : rx_data and the error flags are valid
//   rx_ready   : consumer accepts the word when rx_valid & rx_ready
//   parity_err : parity mismatch on the held word
//   frame_err  : a stop bit was sampled low on the held word
//   overrun    : sticky, a frame was dropped because the held word was not taken
//   busy       : receiver is in the middle of a frame
// The receiver connects through modport master; the consumer through slave.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core -- oversampling UART receiver with a ready/valid output stage.
//   clk : single clock, all logic on the rising edge
//   rst : synchronous, active-low reset
//   si  : asynchronous serial line, idle high, LSB first
//   rx  : uart_rx_if.master -- data word, valid/ready handshake, error flags, busy
// The line is resynchronised, the start bit is confirmed at its midpoint, and
// every following bit is sampled one bit period later. The word and its flags
// are held until accepted; a frame that completes while the held word is still
// pending is dropped and flagged as overrun.
module uart_rx_core #(
  parameter int CLK_FREQ  = 200000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic si,
  uart_rx_if.master rx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int BW           = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Two-flop synchronizer; both flops reset to the idle line level so that
  // leaving reset never looks like a falling edge.
  logic si_meta;
  logic si_sync;

  state_t                state, state_next;
  logic [CW-1:0]         clk_cnt, clk_cnt_next;
  logic [BW-1:0]         bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0]  shift, shift_next;
  logic                  par_bit, par_bit_next;
  logic                  ferr_acc, ferr_next;
  logic                  done, done_next;

  logic                  par_calc;
  logic                  par_err_calc;
  logic                  accept;

  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers update from the same pre-edge values; blocking assignments here
  // would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      si_meta <= 1'b1;
      si_sync <= 1'b1;
    end else begin
      si_meta <= si;
      si_sync <= si_meta;
    end
  end

  // NOTE: the shift register is reset along with the control state; it is a
  // handful of flops, and a known value keeps reset behaviour deterministic.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      clk_cnt  <= clk_cnt_next;
      bit_cnt  <= bit_cnt_next;
      shift    <= shift_next;
      par_bit  <= par_bit_next;
      ferr_acc <= ferr_next;
      done     <= done_next;
    end
  end

  // NOTE: each variable gets a default at the top of the block so that no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    par_bit_next = par_bit;
    ferr_next    = ferr_acc;
    done_next    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!si_sync) begin
          state_next   = S_START;
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          ferr_next    = 1'b0;
        end
      end

      // Confirm the start bit at its midpoint; a high line means a glitch.
      S_START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_next = '0;
          state_next   = si_sync ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end

      // Shifting in at the MSB end leaves bit i at position i after the last
      // sample, since the line is LSB first.
      S_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          shift_next   = {si_sync, shift[DATA_BITS-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end

      S_PARITY: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          par_bit_next = si_sync;
          state_next   = S_STOP;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end

      // Return to idle straight after the last stop sample so a back-to-back
      // start bit is caught without waiting for the stop bit to end.
      S_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          if (!si_sync) begin
            ferr_next = 1'b1;
          end
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_next = '0;
            state_next   = S_IDLE;
            done_next    = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // XOR over data and received parity bit: odd parity expects 1, even expects 0.
  assign par_calc = (^shift) ^ par_bit;

  always_comb begin
    par_err_calc = 1'b0;
    if (PARITY == 1) begin
      par_err_calc = ~par_calc;
    end else if (PARITY == 2) begin
      par_err_calc = par_calc;
    end
  end

  assign accept  = rx.rx_valid & rx.rx_ready;
  assign rx.busy = (state != S_IDLE);

  // Output holding stage. A completed frame loads when the slot is empty or is
  // being emptied in this very cycle; otherwise it is dropped as an overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      if (done && (!rx.rx_valid || rx.rx_ready)) begin
        rx.rx_data    <= shift;
        rx.parity_err <= par_err_calc;
        rx.frame_err  <= ferr_acc;
        rx.rx_valid   <= 1'b1;
      end else if (accept) begin
        rx.rx_valid   <= 1'b0;
      end

      if (done && rx.rx_valid && !rx.rx_ready) begin
        rx.overrun <= 1'b1;
      end else if (accept) begin
        rx.overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLK_FREQ, default 200000000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division), HALF_BIT = CLKS_PER_BIT/2.
REQ-003 Parameter DATA_BITS, default 8, legal 5..9, data bits per frame.
REQ-004 Parameter PARITY, default 0; 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, legal 1..2.
REQ-006 CLK  input  1  single clock; all logic on rising edge.
REQ-007 RST  input  1  reset, synchronous, active-low.
REQ-008 SI  input  1  asynchronous serial line, idle high, LSB first.
REQ-009 RX_DATA  output  DATA_BITS  received data word.
REQ-010 RX_VALID  output  1  RX_DATA and error flags valid.
REQ-011 RX_READY  input  1  consumer accepts word when RX_VALID & RX_READY.
REQ-012 PARITY_ERR  output  1  parity mismatch on held word; 0 when PARITY=0.
REQ-013 FRAME_ERR  output  1  any stop bit sampled low on held word.
REQ-014 OVERRUN  output  1  sticky: a frame completed while RX_VALID high and not accepted.
REQ-015 BUSY  output  1  high whenever FSM not in IDLE.

Function
REQ-016 SI SHALL pass a 2-flop synchronizer; all sampling uses the synchronized signal (2-cycle input latency).
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: synchronized SI low -> START, bit counter cleared, clock counter cleared.
REQ-019 START: after HALF_BIT cycles sample SI; low -> DATA; high -> IDLE (false start, nothing reported).
REQ-020 DATA: sample every CLKS_PER_BIT cycles from start-bit midpoint; bit i stored to shift register position i; after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
REQ-021 PARITY: one sample; odd: error if XOR(data,bit)=0; even: error if XOR(data,bit)=1.
REQ-022 STOP: STOP_BITS samples at CLKS_PER_BIT spacing; any low sample sets frame error; after last sample -> IDLE same cycle, no wait for bit end.
REQ-023 On last stop sample, the cycle after SHALL load RX_DATA, PARITY_ERR, FRAME_ERR and set RX_VALID=1; data delivered even with errors.
REQ-024 RX_VALID SHALL hold, with RX_DATA/flags stable, until a cycle with RX_VALID & RX_READY; it then clears next cycle unless a new word loads in that same cycle.
REQ-025 Frame completing while RX_VALID=1 and RX_READY=0: held word kept, new word dropped, OVERRUN=1.
REQ-026 Frame completing in same cycle as acceptance: new word loads, RX_VALID stays 1, no overrun.
REQ-027 OVERRUN SHALL clear only on reset or on an accepting handshake.
REQ-028 Counters SHALL be sized $clog2(CLKS_PER_BIT+1) and $clog2(DATA_BITS+1); no wrap during a frame.
REQ-029 Receiver SHALL accept a new start bit in IDLE immediately after stop-bit sample (back-to-back frames).

Reset
REQ-030 RST=0 at a clock edge SHALL force IDLE, RX_DATA=0, RX_VALID=0, PARITY_ERR=0, FRAME_ERR=0, OVERRUN=0, BUSY=0, synchronizer flops=1, counters=0, including mid-frame.
REQ-031 After RST returns high, a partial frame in progress SHALL not be reported; receiver waits for a fresh falling edge.

Verification (CLK_FREQ=16, BAUD_RATE=1, CLKS_PER_BIT=16, RX_READY=1 unless stated)
REQ-032 8N1, send 0xA5 -> RX_VALID one cycle, RX_DATA=0xA5, PARITY_ERR=0, FRAME_ERR=0, BUSY low after stop sample.
REQ-033 DATA_BITS=8, PARITY=2, send 0x07 with parity bit 0 -> RX_DATA=0x07, PARITY_ERR=1; same with parity bit 1 -> PARITY_ERR=0.
REQ-034 STOP_BITS=2, send 0x3C with second stop bit 0 -> RX_DATA=0x3C, FRAME_ERR=1.
REQ-035 RX_READY=0, send 0x11 then 0x22 -> RX_DATA stays 0x11, OVERRUN=1; raise RX_READY -> one accept, RX_VALID=0, OVERRUN=0.
REQ-036 SI low for 4 cycles then high -> no RX_VALID, FSM back in IDLE by cycle 11.
REQ-037 RST=0 during data bit 3 of 0xFF, release, then send 0x5A -> outputs zero during reset, single word RX_DATA=0x5A, no errors.
